// File: rtl/frog_mover.sv
// Frog position controller: synchronises the four direction keys, applies one
// grid step per accepted press with a cooldown, respawns on hit, freezes on win.
module frog_mover #(
  parameter int unsigned MOVE_COOLDOWN = 8,
  parameter int unsigned START_ROW     = 15,
  parameter int unsigned START_COL     = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_up,
  input  logic              key_down,
  input  logic              key_left,
  input  logic              key_right,
  input  logic              hit,
  input  logic              restart,
  output logic [3:0]        frog_row,
  output logic [3:0]        frog_col,
  output logic [15:0][15:0] GreenPixels,
  output logic              frozen
);

  typedef enum logic {PLAY, WON} state_t;

  localparam int CW = 20;
  localparam logic [3:0]    START_ROW_V = 4'(START_ROW);
  localparam logic [3:0]    START_COL_V = 4'(START_COL);
  localparam logic [CW-1:0] COOLDOWN_V  = CW'(MOVE_COOLDOWN);

  // Key vector order: [3]=up, [2]=down, [1]=left, [0]=right
  logic [3:0] keyRaw;
  logic [3:0] sync1, sync2, prev;
  logic [3:0] rise;

  state_t        state, stateNext;
  logic [3:0]    rowNext, colNext;
  logic [CW-1:0] cooldown, cooldownNext;

  assign keyRaw = {key_up, key_down, key_left, key_right};
  assign rise   = sync2 & ~prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= keyRaw;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= PLAY;
      frog_row <= START_ROW_V;
      frog_col <= START_COL_V;
      cooldown <= '0;
    end else begin
      state    <= stateNext;
      frog_row <= rowNext;
      frog_col <= colNext;
      cooldown <= cooldownNext;
    end
  end

  // Priority restart > hit > move; a blocked move is a no-op and loads no cooldown
  always_comb begin
    stateNext    = state;
    rowNext      = frog_row;
    colNext      = frog_col;
    cooldownNext = (cooldown != '0) ? cooldown - 1'b1 : '0;
    if (restart) begin
      stateNext    = PLAY;
      rowNext      = START_ROW_V;
      colNext      = START_COL_V;
      cooldownNext = '0;
    end else if (state == PLAY) begin
      if (hit) begin
        rowNext      = START_ROW_V;
        colNext      = START_COL_V;
        cooldownNext = '0;
      end else if (cooldown == '0) begin
        if (rise[3]) begin
          if (frog_row != 4'd0) begin
            rowNext      = frog_row - 4'd1;
            cooldownNext = COOLDOWN_V;
            if (frog_row == 4'd1) stateNext = WON;
          end
        end else if (rise[2]) begin
          if (frog_row != 4'd15) begin
            rowNext      = frog_row + 4'd1;
            cooldownNext = COOLDOWN_V;
          end
        end else if (rise[1]) begin
          if (frog_col != 4'd0) begin
            colNext      = frog_col - 4'd1;
            cooldownNext = COOLDOWN_V;
          end
        end else if (rise[0]) begin
          if (frog_col != 4'd15) begin
            colNext      = frog_col + 4'd1;
            cooldownNext = COOLDOWN_V;
          end
        end
      end
    end
  end

  always_comb begin
    GreenPixels                     = '0;
    GreenPixels[frog_row][frog_col] = 1'b1;
  end

  assign frozen = (state == WON);

endmodule

// File: tb/tb_frog_mover.sv
// Directed bench for frog_mover: walks the frog through moves, clamps, cooldown,
// hit/restart priority, win freeze and asynchronous reset.
module tb_frog_mover;

  localparam int UP = 0, DOWN = 1, LEFT = 2, RIGHT = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              keyUp, keyDown, keyLeft, keyRight;
  logic              hit, restart;
  logic [3:0]        frogRow, frogCol;
  logic [15:0][15:0] greenPixels;
  logic              frozen;

  int total    = 0;
  int failures = 0;

  frog_mover #(.MOVE_COOLDOWN(8), .START_ROW(15), .START_COL(7)) dut (
    .clk(clk), .reset(reset),
    .key_up(keyUp), .key_down(keyDown), .key_left(keyLeft), .key_right(keyRight),
    .hit(hit), .restart(restart),
    .frog_row(frogRow), .frog_col(frogCol),
    .GreenPixels(greenPixels), .frozen(frozen)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before end of sequence");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Compares every output against the expected position and win flag
  task automatic checkOutput(input string tag, input int r, input int c, input logic f);
    logic [15:0][15:0] expMap;
    expMap       = '0;
    expMap[r][c] = 1'b1;
    checkVal({tag, ".row"}, 32'(frogRow), 32'(r));
    checkVal({tag, ".col"}, 32'(frogCol), 32'(c));
    checkVal({tag, ".frozen"}, 32'(frozen), 32'(f));
    checkVal({tag, ".popcount"}, 32'($countones(greenPixels)), 32'd1);
    total++;
    assert (greenPixels === expMap) else begin
      failures++;
      $error("[TB] FAIL %s.map observed=%h expected=%h", tag, greenPixels, expMap);
    end
  endtask

  // One-cycle key pulse, returning once the resulting step is visible
  task automatic applyStimulus(input int dir);
    case (dir)
      UP:      keyUp    = 1'b1;
      DOWN:    keyDown  = 1'b1;
      LEFT:    keyLeft  = 1'b1;
      default: keyRight = 1'b1;
    endcase
    tick(1);
    keyUp = 1'b0; keyDown = 1'b0; keyLeft = 1'b0; keyRight = 1'b0;
    tick(2);
  endtask

  initial begin
    reset = 1'b1; hit = 1'b0; restart = 1'b0;
    keyUp = 1'b0; keyDown = 1'b0; keyLeft = 1'b0; keyRight = 1'b0;
    tick(2);
    checkOutput("reset_hold", 15, 7, 1'b0);
    reset = 1'b0;
    tick(1);
    checkOutput("after_reset", 15, 7, 1'b0);

    applyStimulus(UP);
    checkOutput("first_up", 14, 7, 1'b0);
    tick(2);
    applyStimulus(UP);
    checkOutput("up_in_cooldown", 14, 7, 1'b0);
    tick(10);
    applyStimulus(UP);
    checkOutput("up_after_gap", 13, 7, 1'b0);

    for (int i = 0; i < 7; i++) begin
      tick(9);
      applyStimulus(LEFT);
    end
    checkOutput("at_col0", 13, 0, 1'b0);
    tick(6);
    applyStimulus(LEFT);
    checkOutput("left_blocked", 13, 0, 1'b0);
    applyStimulus(RIGHT);
    checkOutput("right_after_block", 13, 1, 1'b0);

    for (int i = 0; i < 3; i++) begin
      tick(9);
      applyStimulus(UP);
    end
    checkOutput("row10", 10, 1, 1'b0);

    // hit lands in the same cycle the synchronised up edge is live
    tick(9);
    keyUp = 1'b1;
    tick(2);
    hit = 1'b1;
    tick(1);
    hit = 1'b0; keyUp = 1'b0;
    checkOutput("hit_beats_up", 15, 7, 1'b0);
    tick(3);
    checkOutput("no_late_step", 15, 7, 1'b0);

    applyStimulus(UP);
    checkOutput("up_before_hit", 14, 7, 1'b0);
    hit = 1'b1;
    tick(1);
    hit = 1'b0;
    checkOutput("hit_respawn", 15, 7, 1'b0);
    applyStimulus(RIGHT);
    checkOutput("hit_clears_cooldown", 15, 8, 1'b0);

    tick(9);
    applyStimulus(DOWN);
    checkOutput("down_blocked", 15, 8, 1'b0);
    applyStimulus(UP);
    checkOutput("up_after_down_block", 14, 8, 1'b0);

    tick(9);
    keyUp = 1'b1; keyRight = 1'b1;
    tick(1);
    keyUp = 1'b0; keyRight = 1'b0;
    tick(2);
    checkOutput("up_beats_right", 13, 8, 1'b0);

    tick(9);
    keyRight = 1'b1;
    tick(20);
    checkOutput("held_key_once", 13, 9, 1'b0);
    keyRight = 1'b0;
    tick(1);

    tick(9);
    applyStimulus(LEFT);
    checkOutput("left_before_reset", 13, 8, 1'b0);
    tick(2);
    reset = 1'b1;
    #1;
    checkOutput("async_reset", 15, 7, 1'b0);
    tick(1);
    reset = 1'b0;
    tick(1);
    applyStimulus(UP);
    checkOutput("up_after_reset", 14, 7, 1'b0);

    for (int i = 0; i < 13; i++) begin
      tick(9);
      applyStimulus(UP);
    end
    checkOutput("row1", 1, 7, 1'b0);
    tick(9);
    applyStimulus(UP);
    checkOutput("won", 0, 7, 1'b1);

    tick(9);
    applyStimulus(DOWN);
    tick(9);
    applyStimulus(LEFT);
    hit = 1'b1;
    tick(1);
    hit = 1'b0;
    checkOutput("frozen_ignores", 0, 7, 1'b1);

    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    checkOutput("restart_from_won", 15, 7, 1'b0);

    applyStimulus(UP);
    checkOutput("up_before_restart", 14, 7, 1'b0);
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    checkOutput("restart_play", 15, 7, 1'b0);
    applyStimulus(UP);
    checkOutput("restart_clears_cooldown", 14, 7, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", total, failures);
    $finish;
  end

endmodule
